// File: rtl/mult_div_unit.sv
// Iterative unsigned multiply/divide unit with HI/LO result registers.
// Define MDU_DIV_EN to build the restoring divider; otherwise DIVU is a no-op.
module mult_div_unit #(
    parameter int WORD_LENGTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [1:0]             op,
    input  logic [WORD_LENGTH-1:0] dataA,
    input  logic [WORD_LENGTH-1:0] dataB,
    output logic                   busy,
    output logic                   done,
    output logic                   div_by_zero,
    output logic [WORD_LENGTH-1:0] hi,
    output logic [WORD_LENGTH-1:0] lo
);

    localparam int W  = WORD_LENGTH;
    localparam int CW = $clog2(WORD_LENGTH + 1);

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_DIVU  = 2'b01;
    localparam logic [1:0] OP_MTHI  = 2'b10;
    localparam logic [1:0] OP_MTLO  = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } state_t;

    state_t        state;
    logic [W-1:0]  acc_hi;
    logic [W-1:0]  acc_lo;
    logic [W-1:0]  opnd;
    logic [CW-1:0] cnt;

    logic          last;
    logic [W:0]    mul_sum;
    logic [W-1:0]  mul_hi;
    logic [W-1:0]  mul_lo;

    assign last = (cnt == CW'(W - 1));

    // acc_lo holds the multiplier and shifts right as product bits fill in
    always_comb begin
        mul_sum = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opnd : '0)};
        mul_hi  = mul_sum[W:1];
        mul_lo  = {mul_sum[0], acc_lo[W-1:1]};
    end

`ifdef MDU_DIV_EN
    logic [W:0]   div_shift;
    logic [W:0]   div_diff;
    logic [W-1:0] div_hi;
    logic [W-1:0] div_lo;

    // acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in
    always_comb begin
        div_shift = {acc_hi, acc_lo[W-1]};
        div_diff  = div_shift - {1'b0, opnd};
        div_hi    = div_diff[W] ? div_shift[W-1:0] : div_diff[W-1:0];
        div_lo    = {acc_lo[W-2:0], ~div_diff[W]};
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            acc_hi      <= '0;
            acc_lo      <= '0;
            opnd        <= '0;
            cnt         <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        div_by_zero <= 1'b0;
                        cnt         <= '0;
                        acc_hi      <= '0;
                        acc_lo      <= dataB;
                        opnd        <= dataA;
                        unique case (op)
                            OP_MULTU: begin
                                state <= MUL;
                                busy  <= 1'b1;
                            end
                            OP_DIVU: begin
`ifdef MDU_DIV_EN
                                if (dataB == '0) begin
                                    state       <= DONE;
                                    done        <= 1'b1;
                                    hi          <= dataA;
                                    lo          <= '1;
                                    div_by_zero <= 1'b1;
                                end else begin
                                    state  <= DIV;
                                    busy   <= 1'b1;
                                    acc_lo <= dataA;
                                    opnd   <= dataB;
                                end
`else
                                state <= DONE;
                                done  <= 1'b1;
`endif
                            end
                            OP_MTHI: begin
                                state <= DONE;
                                done  <= 1'b1;
                                hi    <= dataA;
                            end
                            OP_MTLO: begin
                                state <= DONE;
                                done  <= 1'b1;
                                lo    <= dataA;
                            end
                            default: state <= IDLE;
                        endcase
                    end
                end
                MUL: begin
                    acc_hi <= mul_hi;
                    acc_lo <= mul_lo;
                    cnt    <= cnt + 1'b1;
                    if (last) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        hi    <= mul_hi;
                        lo    <= mul_lo;
                    end
                end
                DIV: begin
`ifdef MDU_DIV_EN
                    acc_hi <= div_hi;
                    acc_lo <= div_lo;
                    cnt    <= cnt + 1'b1;
                    if (last) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        hi    <= div_hi;
                        lo    <= div_lo;
                    end
`else
                    state <= IDLE;
                    busy  <= 1'b0;
`endif
                end
                DONE: state <= IDLE;
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: latency, results, flags, abort and ignore rules.
// Divide checks follow MDU_DIV_EN the same way the design does.
module tb_mult_div_unit;

    localparam int W = 32;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_DIVU  = 2'b01;
    localparam logic [1:0] OP_MTHI  = 2'b10;
    localparam logic [1:0] OP_MTLO  = 2'b11;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] dataA;
    logic [W-1:0] dataB;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int tests = 0;
    int fails = 0;

    logic [63:0] prod;

    mult_div_unit #(.WORD_LENGTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .dataA       (dataA),
        .dataB       (dataB),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request; cycle 1 is the cycle right after the start edge.
    task automatic run_op(input string tag, input logic [1:0] o,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input int exp_lat, input int exp_busy,
                          input logic [W-1:0] exp_hi,
                          input logic [W-1:0] exp_lo,
                          input logic exp_dbz, input int inject_cyc);
        int cyc;
        int busy_n;
        int both;
        int extra;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        dataA = a;
        dataB = b;
        tick();
        start = 1'b0;
        cyc    = 1;
        busy_n = 0;
        both   = 0;
        chk({tag, "_dbz_at_start"}, 64'(div_by_zero),
            64'(exp_lat == 1 ? exp_dbz : 1'b0));
        while (!done && cyc < 100) begin
            if (busy) busy_n++;
            if (cyc == inject_cyc) begin
                start = 1'b1;
                op    = OP_DIVU;
                dataA = 9;
                dataB = 3;
            end else begin
                start = 1'b0;
                dataA = $urandom;
                dataB = $urandom;
            end
            tick();
            cyc++;
        end
        start = 1'b0;
        if (busy && done) both = 1;
        chk({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
        chk({tag, "_busy_cycles"}, 64'(busy_n), 64'(exp_busy));
        chk({tag, "_hi"}, 64'(hi), 64'(exp_hi));
        chk({tag, "_lo"}, 64'(lo), 64'(exp_lo));
        chk({tag, "_dbz"}, 64'(div_by_zero), 64'(exp_dbz));
        extra = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done) extra++;
            if (busy) both = 1;
        end
        chk({tag, "_idle_after"}, {32'(extra), 32'(both)}, 64'd0);
        chk({tag, "_hold"}, {hi, lo}, {exp_hi, exp_lo});
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        dataA = '0;
        dataB = '0;
        tick();
        tick();
        chk("reset_outs", {59'd0, busy, done, div_by_zero, 2'b00}, 64'd0);
        chk("reset_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        run_op("mul_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               33, 32, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 0);
        prod = 64'(32'h1234_5678) * 64'(32'h9ABC_DEF0);
        run_op("mul_mix", OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0,
               33, 32, prod[63:32], prod[31:0], 1'b0, 0);
        run_op("mul_zero", OP_MULTU, 32'h0, 32'hDEAD_BEEF,
               33, 32, 32'h0, 32'h0, 1'b0, 0);
        run_op("mul_2x3", OP_MULTU, 32'd2, 32'd3,
               33, 32, 32'h0, 32'd6, 1'b0, 0);
        run_op("mthi", OP_MTHI, 32'h1234, 32'hFFFF_0000,
               1, 0, 32'h1234, 32'd6, 1'b0, 0);
        run_op("mtlo", OP_MTLO, 32'hABCD, 32'h5555_5555,
               1, 0, 32'h1234, 32'hABCD, 1'b0, 0);

`ifdef MDU_DIV_EN
        run_op("div_100_7", OP_DIVU, 32'd100, 32'd7,
               33, 32, 32'd2, 32'd14, 1'b0, 0);
        run_op("div_3_7", OP_DIVU, 32'd3, 32'd7,
               33, 32, 32'd3, 32'd0, 1'b0, 0);
        run_op("div_max_16", OP_DIVU, 32'hFFFF_FFFF, 32'h10,
               33, 32, 32'hF, 32'h0FFF_FFFF, 1'b0, 0);
        run_op("div_5_0", OP_DIVU, 32'd5, 32'd0,
               1, 0, 32'd5, 32'hFFFF_FFFF, 1'b1, 0);
`else
        run_op("divu_off", OP_DIVU, 32'd100, 32'd7,
               1, 0, 32'h1234, 32'hABCD, 1'b0, 0);
`endif

        run_op("mul_3x4_inj", OP_MULTU, 32'd3, 32'd4,
               33, 32, 32'h0, 32'd12, 1'b0, 5);

        // Abort MULTU 7x7 with reset in cycle 10
        @(negedge clk);
        start = 1'b1;
        op    = OP_MULTU;
        dataA = 32'd7;
        dataB = 32'd7;
        tick();
        start = 1'b0;
        for (int c = 1; c < 10; c++) tick();
        reset = 1'b0;
        tick();
        chk("abort_busy_done", {62'd0, busy, done}, 64'd0);
        chk("abort_hilo", {hi, lo}, 64'd0);
        reset = 1'b1;
        begin
            int pulses = 0;
            for (int c = 0; c < 40; c++) begin
                tick();
                if (done || busy) pulses++;
            end
            chk("abort_no_done", 64'(pulses), 64'd0);
        end
        run_op("mul_after_abort", OP_MULTU, 32'd2, 32'd3,
               33, 32, 32'h0, 32'd6, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter WORD_LENGTH, default 32: operand width and HI/LO register width.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port op  input  2  operation select: 00 MULTU, 01 DIVU, 10 MTHI, 11 MTLO.
REQ-006 SHALL have port dataA  input  WORD_LENGTH  multiplicand / dividend / move source.
REQ-007 SHALL have port dataB  input  WORD_LENGTH  multiplier / divisor; ignored for MTHI/MTLO.
REQ-008 SHALL have port busy  output  1  high while an operation is in progress (MUL or DIV state).
REQ-009 SHALL have port done  output  1  single-cycle completion pulse.
REQ-010 SHALL have port div_by_zero  output  1  flag for the last completed DIVU with dataB = 0.
REQ-011 SHALL have port hi  output  WORD_LENGTH  HI register.
REQ-012 SHALL have port lo  output  WORD_LENGTH  LO register.

Function
REQ-013 SHALL implement the FSM states IDLE, MUL, DIV and DONE.
REQ-014 SHALL, in IDLE with start=1, latch op, dataA and dataB and clear div_by_zero at that edge (the "start edge").
REQ-015 SHALL, on a MULTU start, go to MUL for exactly WORD_LENGTH cycles, retiring one bit per cycle (unsigned shift-add), then go to DONE.
REQ-016 SHALL, on a DIVU start with dataB≠0, go to DIV for exactly WORD_LENGTH cycles, retiring one quotient bit per cycle (unsigned restoring division), then go to DONE.
REQ-017 SHALL place results as follows: MULTU writes hi = upper half and lo = lower half of the 2*WORD_LENGTH product; DIVU writes lo = quotient and hi = remainder.
REQ-018 SHALL, on a DIVU start with dataB=0, go directly to DONE and write lo = all ones, hi = dataA and div_by_zero = 1.
REQ-019 SHALL, on an MTHI or MTLO start, go directly to DONE, write hi (or lo) = dataA and leave the other register unchanged.
REQ-020 SHALL update hi and lo only on the edge entering DONE; partial results SHALL live in internal registers only.
REQ-021 SHALL assert done only in DONE, for exactly one cycle, then return to IDLE.
REQ-022 SHALL give these latencies from the start edge: done high in cycle WORD_LENGTH+1 for MULTU/DIVU, and in cycle 1 for MTHI/MTLO and divide-by-zero.
REQ-023 SHALL ignore start in MUL, DIV and DONE; operands and op change nothing while not in IDLE.
REQ-024 SHALL hold hi, lo and div_by_zero stable between completions.
REQ-025 SHALL keep busy and done mutually exclusive.

Reset
REQ-026 SHALL, when reset=0 at a rising edge, force state=IDLE, busy=0, done=0, div_by_zero=0, hi=0, lo=0 and clear all internal registers.
REQ-027 SHALL, on reset during MUL or DIV, abort the operation with no done pulse; start is honoured again from the first edge after reset returns high.

Configuration
REQ-028 SHALL, with macro MDU_DIV_EN defined, implement DIVU per REQ-016 and REQ-018.
REQ-029 SHALL, without MDU_DIV_EN, exclude all divider logic: a DIVU start goes to DONE (done in cycle 1) with hi, lo unchanged and div_by_zero = 0.

Verification (WORD_LENGTH=32, cycles counted from the start edge)
REQ-030 MULTU 0xFFFFFFFF×0xFFFFFFFF -> busy cycles 1-32, done cycle 33, hi=0xFFFFFFFE, lo=0x00000001.
REQ-031 DIVU 100/7 (MDU_DIV_EN) -> done cycle 33, lo=14, hi=2, div_by_zero=0.
REQ-032 DIVU 5/0 (MDU_DIV_EN) -> done cycle 1, lo=0xFFFFFFFF, hi=5, div_by_zero=1; flag clears on next start edge.
REQ-033 MULTU 3×4 with a second start (DIVU 9/3) in cycle 5 -> single done at cycle 33, hi=0, lo=12; second request ignored.
REQ-034 reset=0 in cycle 10 of MULTU 7×7 -> next cycle busy=0, hi=lo=0, no done pulse; fresh MULTU 2×3 then yields lo=6.
REQ-035 MTHI 0x1234 after MULTU 2×3 -> done cycle 1, hi=0x1234, lo=6; DIVU without MDU_DIV_EN -> done cycle 1, hi/lo unchanged.
